// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline slice.
//   stage_state_e  : occupancy state of one skid stage (EMPTY, HALF, FULL)
//   MAX_PIPE_DEPTH : largest supported number of chained stages
//   cnt_width()    : width of the occupancy counter for a given depth; never
//                    returns 0 so that a DEPTH=0 build still has a legal port
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned MAX_PIPE_DEPTH = 32'd16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        if (depth == 32'd0) begin
            return 32'd1;
        end else begin
            return $clog2(32'd2 * depth + 32'd1);
        end
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// One fully registered valid/ready skid stage holding up to two entries.
// The main register always drives o_data; the skid register catches the word
// accepted in the cycle where downstream stalls, which lets i_ready come
// straight from a flop instead of from o_ready.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_valid, i_ready : upstream handshake (i_ready registered)
//   i_data           : upstream data
//   o_valid, o_ready : downstream handshake (o_valid registered)
//   o_data           : downstream data (main register)
// -----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data
);

    stage_state_e     state_r;
    stage_state_e     state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic             ready_r;
    logic             valid_r;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             load_main_in_s;
    logic             load_main_skid_s;
    logic             load_skid_s;

    assign in_xfer_s  = i_valid & ready_r;
    assign out_xfer_s = valid_r & o_ready;

    assign i_ready = ready_r;
    assign o_valid = valid_r;
    assign o_data  = main_r;

    // Next-state and register-load decode for the EMPTY/HALF/FULL machine
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            EMPTY: begin
                if (in_xfer_s) begin
                    state_nxt_s    = HALF;
                    load_main_in_s = 1'b1;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            HALF: begin
                if (in_xfer_s && out_xfer_s) begin
                    state_nxt_s    = HALF;
                    load_main_in_s = 1'b1;
                end else if (in_xfer_s) begin
                    state_nxt_s = FULL;
                    load_skid_s = 1'b1;
                end else if (out_xfer_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = HALF;
                end
            end
            FULL: begin
                // ready_r is low in FULL, so no input transfer can arrive here
                if (out_xfer_s) begin
                    state_nxt_s      = HALF;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State and registered handshake outputs, derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != FULL);
            valid_r <= (state_nxt_s != EMPTY);
        end
    end

    // Main data register: loads only from input or skid on a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r <= {WIDTH{1'b0}};
        end else if (load_main_in_s) begin
            main_r <= i_data;
        end else if (load_main_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid data register: catches the word accepted while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_r <= {WIDTH{1'b0}};
        end else if (load_skid_s) begin
            skid_r <= i_data;
        end else begin
            skid_r <= skid_r;
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// -----------------------------------------------------------------------------
// elastic_pipe
// Chain of DEPTH pipe_skid_stage instances forming a registered valid/ready
// pipeline with capacity 2*DEPTH. DEPTH=0 degenerates to plain wires.
// Optional feature macro: PIPE_OCCUPANCY_EN adds the o_count occupancy port.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_valid, i_ready : upstream handshake
//   i_data           : upstream data (WIDTH bits)
//   o_valid, o_ready : downstream handshake
//   o_data           : downstream data (WIDTH bits)
//   o_count          : entries held (only with PIPE_OCCUPANCY_EN)
// -----------------------------------------------------------------------------
module elastic_pipe
    import pipe_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data
`ifdef PIPE_OCCUPANCY_EN
    ,
    output logic [CNT_W-1:0] o_count
`endif
);

    generate
        if (DEPTH == 32'd0) begin : g_wire
            assign o_valid = i_valid;
            assign o_data  = i_data;
            assign i_ready = o_ready;
        end else begin : g_chain
            // Index k is the input side of stage k; index DEPTH is the output
            logic [DEPTH:0]            valid_s;
            logic [DEPTH:0]            ready_s;
            logic [DEPTH:0][WIDTH-1:0] data_s;

            assign valid_s[0]     = i_valid;
            assign data_s[0]      = i_data;
            assign i_ready        = ready_s[0];
            assign o_valid        = valid_s[DEPTH];
            assign o_data         = data_s[DEPTH];
            assign ready_s[DEPTH] = o_ready;

            for (genvar k = 0; k < DEPTH; k++) begin : g_stage
                pipe_skid_stage #(
                    .WIDTH (WIDTH)
                ) u_stage (
                    .clk     (clk),
                    .rst     (rst),
                    .i_valid (valid_s[k]),
                    .i_ready (ready_s[k]),
                    .i_data  (data_s[k]),
                    .o_valid (valid_s[k+1]),
                    .o_ready (ready_s[k+1]),
                    .o_data  (data_s[k+1])
                );
            end
        end
    endgenerate

`ifdef PIPE_OCCUPANCY_EN
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_in_s;
    logic             cnt_out_s;

    assign cnt_in_s  = i_valid & i_ready;
    assign cnt_out_s = o_valid & o_ready;
    assign o_count   = cnt_r;

    // Occupancy counter; capacity back-pressure keeps it within 2*DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_in_s && !cnt_out_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else if (!cnt_in_s && cnt_out_s) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe
// Self-checking bench: a DEPTH=2 pipe driven from a directed vector table plus
// streaming and random back-pressure sequences, and a DEPTH=0 pipe checked as
// pure wires. Inputs change on the falling edge; outputs are sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_elastic_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_data;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_data;

    logic        z_i_valid;
    logic        z_i_ready;
    logic [15:0] z_i_data;
    logic        z_o_valid;
    logic        z_o_ready;
    logic [15:0] z_o_data;

`ifdef PIPE_OCCUPANCY_EN
    logic [2:0]  o_count;
    logic [0:0]  z_o_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    elastic_pipe #(.WIDTH(16), .DEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data)
`ifdef PIPE_OCCUPANCY_EN
        ,
        .o_count (o_count)
`endif
    );

    elastic_pipe #(.WIDTH(16), .DEPTH(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (z_i_valid),
        .i_ready (z_i_ready),
        .i_data  (z_i_data),
        .o_valid (z_o_valid),
        .o_ready (z_o_ready),
        .o_data  (z_o_data)
`ifdef PIPE_OCCUPANCY_EN
        ,
        .o_count (z_o_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; i_data = 16'h0000; o_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        eov;
        logic        eir;
        logic [15:0] eod;
        int          ecnt;
    } vec_t;

    vec_t tbl [21];

    logic [15:0] sb [$];
    logic [15:0] exp_w;
    logic [15:0] hold_d;
    logic        stall;
    int          tx;
    int          rx;
    int          cyc;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = 16'h0000; o_ready = 1'b0;
        z_i_valid = 1'b0; z_i_data = 16'h0000; z_o_ready = 1'b0;

        //                 rst   iv    id        ordy  eov   eir   eod       cnt
        tbl[0]  = '{1'b0, 1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 16'h0000, 0};
        tbl[1]  = '{1'b0, 1'b1, 16'h00A2, 1'b0, 1'b0, 1'b1, 16'h0000, 1};
        tbl[2]  = '{1'b0, 1'b1, 16'h00A3, 1'b0, 1'b1, 1'b1, 16'h00A1, 2};
        tbl[3]  = '{1'b0, 1'b1, 16'h00A4, 1'b0, 1'b1, 1'b1, 16'h00A1, 3};
        tbl[4]  = '{1'b0, 1'b1, 16'h00A5, 1'b0, 1'b1, 1'b0, 16'h00A1, 4};
        tbl[5]  = '{1'b0, 1'b1, 16'h00A5, 1'b1, 1'b1, 1'b0, 16'h00A1, 4};
        tbl[6]  = '{1'b0, 1'b1, 16'h00A5, 1'b1, 1'b1, 1'b0, 16'h00A2, 3};
        tbl[7]  = '{1'b0, 1'b1, 16'h00A5, 1'b1, 1'b1, 1'b1, 16'h00A3, 2};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00A4, 2};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h00A5, 1};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h00A5, 1};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00A5, 1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00A5, 0};
        tbl[13] = '{1'b0, 1'b1, 16'h00B1, 1'b0, 1'b0, 1'b1, 16'h00A5, 0};
        tbl[14] = '{1'b0, 1'b1, 16'h00B2, 1'b0, 1'b0, 1'b1, 16'h00A5, 1};
        tbl[15] = '{1'b0, 1'b1, 16'h00B3, 1'b0, 1'b1, 1'b1, 16'h00B1, 2};
        tbl[16] = '{1'b1, 1'b1, 16'h00B4, 1'b1, 1'b1, 1'b1, 16'h00B1, 3};
        tbl[17] = '{1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
        tbl[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1};
        tbl[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hBEEF, 1};
        tbl[20] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF, 0};

        // Directed table: fill to capacity, drain, hold under stall, reset mid-stream
        do_reset();
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; i_valid = tbl[i].iv; i_data = tbl[i].id; o_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d o_valid", i), {31'd0, o_valid}, {31'd0, tbl[i].eov});
            chk($sformatf("tbl%0d i_ready", i), {31'd0, i_ready}, {31'd0, tbl[i].eir});
            chk($sformatf("tbl%0d o_data", i), {16'd0, o_data}, {16'd0, tbl[i].eod});
`ifdef PIPE_OCCUPANCY_EN
            chk($sformatf("tbl%0d o_count", i), {29'd0, o_count}, tbl[i].ecnt);
`endif
        end

        // Streaming: 0x0001..0x0010 back-to-back, two-cycle latency, no bubbles
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            o_ready = 1'b1;
            i_valid = (c < 16);
            i_data  = (c < 16) ? 16'(c + 1) : 16'h0000;
            #1;
            if (c < 16) chk($sformatf("stream c%0d i_ready", c), {31'd0, i_ready}, 32'd1);
            if (c < 2) begin
                chk($sformatf("stream c%0d o_valid", c), {31'd0, o_valid}, 32'd0);
            end else if (c < 18) begin
                chk($sformatf("stream c%0d o_valid", c), {31'd0, o_valid}, 32'd1);
                chk($sformatf("stream c%0d o_data", c), {16'd0, o_data}, 32'(c - 1));
            end else begin
                chk($sformatf("stream c%0d o_valid", c), {31'd0, o_valid}, 32'd0);
            end
`ifdef PIPE_OCCUPANCY_EN
            if (c >= 2 && c <= 16) chk($sformatf("stream c%0d o_count", c), {29'd0, o_count}, 32'd2);
`endif
        end

        // Random back-pressure with scoreboard and stall-stability check
        do_reset();
        tx = 0; rx = 0; cyc = 0; stall = 1'b0; hold_d = 16'h0000;
        while (rx < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            o_ready = 1'($urandom_range(1, 0));
            i_valid = (tx < 1000) && ($urandom_range(3, 0) != 0);
            i_data  = 16'($urandom);
            #1;
            if (stall) begin
                chk("stall hold", {15'd0, o_valid, o_data}, {15'd0, 1'b1, hold_d});
            end
            stall  = o_valid & ~o_ready;
            hold_d = o_data;
            if (i_valid && i_ready) begin
                sb.push_back(i_data);
                tx++;
            end
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    chk("rand unexpected output", 32'd1, 32'd0);
                end else begin
                    exp_w = sb.pop_front();
                    chk("rand data", {16'd0, o_data}, {16'd0, exp_w});
                end
                rx++;
            end
        end
        chk("rand received count", rx, 32'd1000);
        chk("rand leftover", sb.size(), 32'd0);

        // DEPTH=0 pass-through, same-cycle combinational behaviour
        @(negedge clk);
        z_i_valid = 1'b1; z_i_data = 16'h1234; z_o_ready = 1'b0;
        #1;
        chk("d0 o_valid", {31'd0, z_o_valid}, 32'd1);
        chk("d0 o_data", {16'd0, z_o_data}, 32'h1234);
        chk("d0 i_ready low", {31'd0, z_i_ready}, 32'd0);
        z_o_ready = 1'b1; z_i_data = 16'h5A5A;
        #1;
        chk("d0 i_ready high", {31'd0, z_i_ready}, 32'd1);
        chk("d0 o_data2", {16'd0, z_o_data}, 32'h5A5A);
        z_i_valid = 1'b0;
        #1;
        chk("d0 o_valid low", {31'd0, z_o_valid}, 32'd0);
`ifdef PIPE_OCCUPANCY_EN
        chk("d0 o_count", {31'd0, z_o_count}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
